// File: rtl/camellia_pkg.sv
// ============================================================================
// Module   : camellia_pkg
// Brief    : Shared widths, loader FSM states and core latency for Camellia-128
// Revision : 1.0
// ============================================================================
`default_nettype none

package camellia_pkg;

  localparam int BLOCK_W      = 128;
  localparam int WORD_W       = 32;
  localparam int NWORDS       = BLOCK_W / WORD_W;
  localparam int CORE_LATENCY = 27;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/camellia_word_packer.sv
// ============================================================================
// Module   : camellia_word_packer
// Brief    : MSB-first word shifter; o_full pulses with the assembled block
// Revision : 1.0
// ============================================================================
`default_nettype none

module camellia_word_packer #(
  parameter int WORD_W = 32,
  parameter int NWORDS = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_load,
  input  logic [WORD_W-1:0]          i_word,
  output logic                       o_full,
  output logic [NWORDS*WORD_W-1:0]   o_block
);

  localparam int BW    = NWORDS * WORD_W;
  localparam int CNT_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(NWORDS - 1);

  // Only the lower NWORDS-1 words are kept; the newest word completes the block.
  logic [BW-WORD_W-1:0] r_sr;
  logic [CNT_W-1:0]     r_cnt;
  logic                 w_last;

  assign w_last  = (r_cnt == C_LAST);
  assign o_full  = i_load & w_last;
  assign o_block = {r_sr, i_word};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_sr  <= o_block[BW-WORD_W-1:0];
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/camellia_input_loader.sv
// ============================================================================
// Module   : camellia_input_loader
// Brief    : Assembles key/data from a word stream and starts the Camellia core
// Revision : 1.0
// ============================================================================
`default_nettype none

module camellia_input_loader #(
  parameter int WORD_W = 32,
  parameter int NWORDS = 128 / WORD_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WORD_W-1:0]         in_word,
  input  logic                      in_is_key,
  input  logic                      in_dec,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      out_rdy,
  output logic                      data_valid,
  output logic [NWORDS*WORD_W-1:0]  block_out,
  output logic [NWORDS*WORD_W-1:0]  key_out,
  output logic                      dec_out,
  output logic                      key_loaded,
  output logic                      busy
);

  import camellia_pkg::*;

  localparam int BW = NWORDS * WORD_W;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_pending;
  logic            w_key_load;
  logic            w_data_load;
  logic            w_key_full;
  logic            w_data_full;
  logic [BW-1:0]   w_key_asm;
  logic [BW-1:0]   w_data_asm;

  // A completed data block waits here for the key; further data is refused.
  assign w_key_load  = in_valid & in_ready & in_is_key;
  assign w_data_load = in_valid & in_ready & ~in_is_key & ~r_pending;

  camellia_word_packer #(.WORD_W(WORD_W), .NWORDS(NWORDS)) u_key_packer (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_key_load),
    .i_word  (in_word),
    .o_full  (w_key_full),
    .o_block (w_key_asm)
  );

  camellia_word_packer #(.WORD_W(WORD_W), .NWORDS(NWORDS)) u_data_packer (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_data_load),
    .i_word  (in_word),
    .o_full  (w_data_full),
    .o_block (w_data_asm)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= FILL;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    data_valid  = 1'b0;
    busy        = 1'b0;
    unique case (r_state)
      FILL: begin
        in_ready = ~rst;
        if ((w_data_full && key_loaded) || (w_key_full && r_pending))
          w_state_nxt = ISSUE;
      end
      ISSUE: begin
        data_valid  = 1'b1;
        busy        = 1'b1;
        w_state_nxt = BUSY;
      end
      BUSY: begin
        busy = 1'b1;
        // out_rdy stays high after completion, so it only matters here.
        if (out_rdy) w_state_nxt = FILL;
      end
      default: w_state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_out    <= '0;
      block_out  <= '0;
      dec_out    <= 1'b0;
      key_loaded <= 1'b0;
      r_pending  <= 1'b0;
    end else begin
      if (w_key_full) begin
        key_out    <= w_key_asm;
        key_loaded <= 1'b1;
        r_pending  <= 1'b0;
      end
      if (w_data_full) begin
        block_out <= w_data_asm;
        dec_out   <= in_dec;
        if (!key_loaded) r_pending <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_camellia_input_loader.sv
// ============================================================================
// Module   : tb_camellia_input_loader
// Brief    : Directed and random stimulus checked against a queue-based model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_camellia_input_loader;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  in_word;
  logic         in_is_key, in_dec, in_valid, out_rdy;
  logic         in_ready, data_valid, dec_out, key_loaded, busy;
  logic [127:0] block_out, key_out;

  int n_checks = 0;
  int n_err    = 0;

  camellia_input_loader #(.WORD_W(32), .NWORDS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_word    (in_word),
    .in_is_key  (in_is_key),
    .in_dec     (in_dec),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_rdy    (out_rdy),
    .data_valid (data_valid),
    .block_out  (block_out),
    .key_out    (key_out),
    .dec_out    (dec_out),
    .key_loaded (key_loaded),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: words collected in queues; a block "in flight" from the
  // start pulse until the first out_rdy seen after the pulse cycle.
  logic [31:0]  kq[$];
  logic [31:0]  dq[$];
  logic [127:0] m_key, m_block;
  bit m_dec, m_kl, m_pending, m_flight, m_pulse, m_live, m_acc;

  function automatic logic [127:0] join4(input logic [31:0] q[$]);
    return {q[0], q[1], q[2], q[3]};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      kq.delete(); dq.delete();
      m_key = '0; m_block = '0; m_dec = 0; m_kl = 0;
      m_pending = 0; m_flight = 0; m_pulse = 0; m_live = 1;
    end else begin
      m_acc = !m_flight;
      if (m_pulse) m_pulse = 0;
      else if (m_flight && out_rdy) m_flight = 0;
      if (m_acc && in_valid) begin
        if (in_is_key) begin
          kq.push_back(in_word);
          if (kq.size() == 4) begin
            m_key = join4(kq); kq.delete(); m_kl = 1;
            if (m_pending) begin m_pending = 0; m_flight = 1; m_pulse = 1; end
          end
        end else if (!m_pending) begin
          dq.push_back(in_word);
          if (dq.size() == 4) begin
            m_block = join4(dq); dq.delete(); m_dec = in_dec;
            if (m_kl) begin m_flight = 1; m_pulse = 1; end
            else m_pending = 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("in_ready",   in_ready,   !rst && !m_flight);
      check("data_valid", data_valid, m_pulse);
      check("busy",       busy,       m_flight);
      check("key_out",    key_out,    m_key);
      check("block_out",  block_out,  m_block);
      check("dec_out",    dec_out,    m_dec);
      check("key_loaded", key_loaded, m_kl);
    end
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic send(input logic [31:0] w, input logic k, input logic d);
    in_valid = 1; in_word = w; in_is_key = k; in_dec = d;
    tick();
    in_valid = 0;
  endtask

  task automatic do_reset();
    rst = 1; tick(); rst = 0;
  endtask

  task automatic wait_idle(input int max);
    out_rdy = 1;
    for (int i = 0; i < max && busy !== 1'b0; i++) tick();
    check("idle_reached", busy, 1'b0);
    out_rdy = 0;
  endtask

  logic [31:0] kw1[4] = '{32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F};
  logic [31:0] dw1[4] = '{32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98, 32'h76543210};
  logic [31:0] kw2[4] = '{32'h2B7E1516, 32'h28AED2A6, 32'hABF71588, 32'h09CF4F3C};
  logic [31:0] dw2[4] = '{32'hDEADBEEF, 32'h00112233, 32'h44556677, 32'h8899AABB};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; in_valid = 0; in_is_key = 0; in_dec = 0; in_word = '0; out_rdy = 0;
    tick(); tick();
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst = 0;

    // Key load alone
    for (int i = 0; i < 4; i++) send(kw1[i], 1, 0);
    check("t1_key", key_out, 128'h000102030405060708090A0B0C0D0E0F);
    check("t1_model_key", m_key, 128'h000102030405060708090A0B0C0D0E0F);
    check("t1_key_loaded", key_loaded, 1'b1);
    check("t1_no_dv", data_valid, 1'b0);

    // Data block starts the core
    for (int i = 0; i < 4; i++) send(dw1[i], 0, 0);
    check("t2_dv", data_valid, 1'b1);
    check("t2_block", block_out, 128'h0123456789ABCDEFFEDCBA9876543210);
    check("t2_busy", busy, 1'b1);
    check("t2_in_ready", in_ready, 1'b0);
    tick();
    check("t2_dv_once", data_valid, 1'b0);

    // Stall in BUSY with input pressure
    in_valid = 1; in_is_key = 0; in_word = 32'hFFFFFFFF;
    repeat (27) tick();
    check("t3_block_hold", block_out, 128'h0123456789ABCDEFFEDCBA9876543210);
    check("t3_busy_hold", busy, 1'b1);
    in_valid = 0; out_rdy = 1;
    tick();
    check("t3_busy_clr", busy, 1'b0);
    check("t3_ready", in_ready, 1'b1);
    out_rdy = 0;

    // Data before key
    do_reset();
    for (int i = 0; i < 4; i++) send(dw2[i], 0, 1);
    check("t4_no_dv", data_valid, 1'b0);
    for (int i = 0; i < 4; i++) send(kw2[i], 1, 0);
    check("t4_dv", data_valid, 1'b1);
    check("t4_key", key_out, 128'h2B7E151628AED2A6ABF7158809CF4F3C);
    check("t4_block", block_out, 128'hDEADBEEF00112233445566778899AABB);
    check("t4_dec", dec_out, 1'b1);
    wait_idle(10);

    // Interleaved key/data
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send(32'hA0A0A0A0 + i, 1, 0);
      send(32'h0F0F0F00 + i, 0, 0);
    end
    check("t5_dv", data_valid, 1'b1);
    check("t5_key", key_out, 128'hA0A0A0A0A0A0A0A1A0A0A0A2A0A0A0A3);
    check("t5_block", block_out, 128'h0F0F0F000F0F0F010F0F0F020F0F0F03);

    // Reset while busy, then during a partial fill
    tick();
    check("t6_busy", busy, 1'b1);
    do_reset();
    check("t6_rst_key", key_out, 128'h0);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_kl", key_loaded, 1'b0);
    send(32'h11111111, 1, 0); send(32'h22222222, 1, 0);
    send(32'h33333333, 0, 0); send(32'h44444444, 0, 0);
    do_reset();
    check("t6_rst2_block", block_out, 128'h0);
    for (int i = 0; i < 4; i++) send(kw1[i], 1, 0);
    for (int i = 0; i < 4; i++) send(dw1[i], 0, 1);
    check("t6_dv", data_valid, 1'b1);
    check("t6_key", key_out, 128'h000102030405060708090A0B0C0D0E0F);
    check("t6_block", block_out, 128'h0123456789ABCDEFFEDCBA9876543210);
    check("t6_dec", dec_out, 1'b1);
    wait_idle(10);

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      rst       = ($urandom_range(0, 149) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_is_key = $urandom_range(0, 1);
      if (m_pending && !in_is_key) in_is_key = 1;
      in_word   = $urandom;
      in_dec    = $urandom_range(0, 1);
      out_rdy   = ($urandom_range(0, 3) == 0);
      tick();
    end
    rst = 0; in_valid = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/camellia_input_loader.md
Name: camellia_input_loader

Overview:
- Upstream feeder for the Camellia-128 core and its latency counter.
- Assembles 128-bit key and 128-bit plaintext/ciphertext blocks from a 32-bit word stream using a valid/ready handshake.
- Presents the assembled block and key to the core and issues a single-cycle data_valid pulse, which starts the core and restarts the downstream 27-cycle counter.
- Blocks further input until that counter returns out_rdy.

Parameters:
- WORD_W, 32, input word width; must divide 128.
- NWORDS, 128/WORD_W (=4), words per key or block.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_word  in  WORD_W  incoming word; first word is MSB [127:96].
- in_is_key  in  1  1 = word belongs to the key, 0 = word belongs to the data block.
- in_dec  in  1  decrypt mode, sampled with the last data word.
- in_valid  in  1  word present.
- in_ready  out  1  loader can accept a word.
- out_rdy  in  1  from the latency counter; high = core result available.
- data_valid  out  1  one-cycle start pulse to the core and counter.
- block_out  out  128  assembled data block, held stable while BUSY.
- key_out  out  128  assembled key, held stable while BUSY.
- dec_out  out  1  latched mode.
- key_loaded  out  1  a full key has been received since reset.
- busy  out  1  a block is in flight.

Behaviour:
- Reset (rst=1 at posedge): state=FILL, word counters=0, all outputs 0 (block_out, key_out, dec_out, data_valid, key_loaded, busy); in_ready=0 during the reset cycle.
- Transfer occurs when in_valid & in_ready at posedge.
- in_ready = (state==FILL).
- FILL state:
  - A key transfer shifts the word into key_sr, shifting left by WORD_W, and increments key_cnt.
  - On the NWORDS-th key word: key_cnt wraps to 0; key_out <= assembled key, same edge; key_loaded <= 1.
  - A data transfer shifts the word into data_sr and increments data_cnt.
  - On the NWORDS-th data word: data_cnt wraps to 0; block_out <= assembled block; dec_out <= in_dec.
    - If key_loaded=1, or the key completes on the same edge (impossible, since one word per cycle), go to ISSUE.
    - Otherwise the block is held and the state stays FILL with a pending flag set. ISSUE is entered on the edge that completes the key.
  - Key and data counters are independent; interleaving key and data words is legal.
- ISSUE state, exactly 1 cycle: data_valid=1, busy=1, in_ready=0. Next state is BUSY.
  - Latency: data_valid is asserted in the cycle after the last data word is accepted (registered).
- BUSY state: busy=1, in_ready=0.
  - Waits for out_rdy=1. On that edge: busy<=0, next state FILL.
  - out_rdy is ignored in FILL and ISSUE. The counter keeps out_rdy high after completion, so it is qualified only by state==BUSY.
  - key_out, block_out and dec_out must not change while busy.
- Pending data block with no key:
  - Further data words are refused; in_ready for data is taken as in_ready=1 but data transfers are ignored when pending. The bench must not send them.
  - Key words are still accepted.
- Reset mid-operation (any state): immediate return to reset values on that edge. Partial fills are discarded and key_loaded is cleared.
- data_valid is never asserted for more than 1 cycle and never twice without an intervening out_rdy.

Decomposition:
- Package camellia_pkg holds:
  - BLOCK_W=128, WORD_W=32, NWORDS=4;
  - a state enum {FILL, ISSUE, BUSY};
  - the CORE_LATENCY=27 constant shared with the counter.
- One natural sub-module: camellia_word_packer. It contains a shift register, a word counter, and a full pulse, and is instantiated twice (key, data).

Test Plan:
1. Reset then key words 0x00010203, 0x04050607, 0x08090A0B, 0x0C0D0E0F -> key_out=0x000102030405060708090A0B0C0D0E0F, key_loaded=1, no data_valid.
2. Then 4 data words 0x01234567, 0x89ABCDEF, 0xFEDCBA98, 0x76543210 with in_dec=0 -> one cycle later data_valid=1 for exactly 1 cycle; block_out=0x0123456789ABCDEFFEDCBA9876543210; busy=1; in_ready=0.
3. Hold out_rdy=0 for 27 cycles while driving in_valid=1 -> no transfers, outputs stable. Assert out_rdy -> next cycle busy=0, in_ready=1.
4. Data block sent before any key -> no data_valid. Then 4 key words -> data_valid pulses the cycle after the 4th key word, with both the key and the block correct.
5. Interleave key and data words (K, D, K, D, ...) -> both assemble correctly; data_valid after the 4th data word once the key is complete.
6. Assert rst during BUSY and during a 2-word partial fill -> all outputs 0 next cycle. A subsequent full key+data load works from word 0.
